// File: rtl/icache_axi_read_bridge.sv
// Instruction-cache to AXI4 read bridge: turns line-refill / uncached requests into
// one AR burst at a time and streams R beats back, draining them silently on flush.
module icache_axi_read_bridge #(
  parameter int         LINE_WORDS        = 8,
  parameter int         LINE_OFFSET_WIDTH = 5,
  parameter logic [3:0] AXI_ID            = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] c_araddr,
  input  logic        c_arvalid,
  input  logic        c_cached,
  output logic        c_arready,
  output logic [31:0] c_rdata,
  output logic        c_rvalid,
  output logic        c_rlast,
  input  logic        c_rready,
  input  logic        flush,
  output logic        err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] beat_cnt;
  logic       flush_pend;
  logic       accept;
  logic       beat;

  // Flags a beat whose response, ID or RLAST position disagrees with the issued burst.
  function automatic logic beat_error(input logic [1:0] resp, input logic [3:0] id,
                                      input logic last, input logic [7:0] cnt,
                                      input logic [7:0] len);
    return (resp != 2'b00) || (id != AXI_ID) ||
           (last && (cnt != len)) || ((cnt == len) && !last);
  endfunction

  assign accept  = (state == S_IDLE) && !flush && c_arvalid;
  assign beat    = rvalid && rready;
  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_AR;
      S_AR:    if (arready) state_nxt = (flush_pend || flush) ? S_DRAIN : S_R;
      S_R: begin
        if (flush)              state_nxt = S_DRAIN;
        else if (beat && rlast) state_nxt = S_IDLE;
      end
      S_DRAIN: if (rvalid && rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // R channel is a straight pass-through; flush masks it in the same cycle.
  always_comb begin
    arvalid  = (state == S_AR);
    rready   = 1'b0;
    c_rvalid = 1'b0;
    c_rlast  = 1'b0;
    c_rdata  = rdata;
    case (state)
      S_R: begin
        rready   = c_rready && !flush;
        c_rvalid = rvalid && !flush;
        c_rlast  = rlast && !flush;
      end
      S_DRAIN: rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_arready  <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      err        <= 1'b0;
    end else begin
      c_arready <= accept;
      err       <= beat && beat_error(rresp, rid, rlast, beat_cnt, arlen);
      if (accept) begin
        araddr <= c_cached ? {c_araddr[31:LINE_OFFSET_WIDTH], {LINE_OFFSET_WIDTH{1'b0}}}
                           : c_araddr;
        arlen  <= c_cached ? BURST_LEN : 8'd0;
      end
      if (state == S_AR) begin
        if (flush)   flush_pend <= 1'b1;
        if (arready) beat_cnt   <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if ((state == S_DRAIN) && rvalid && rlast) flush_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_axi_read_bridge.sv
// Directed bench for icache_axi_read_bridge with a queue scoreboard and negedge monitor.
module tb_icache_axi_read_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] c_araddr = '0;
  logic        c_arvalid = 1'b0;
  logic        c_cached = 1'b0;
  logic        c_arready;
  logic [31:0] c_rdata;
  logic        c_rvalid;
  logic        c_rlast;
  logic        c_rready = 1'b1;
  logic        flush = 1'b0;
  logic        err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [32:0] exp_r[$];
  logic [39:0] exp_ar[$];

  icache_axi_read_bridge #(.LINE_WORDS(8), .LINE_OFFSET_WIDTH(5), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .c_araddr(c_araddr), .c_arvalid(c_arvalid), .c_cached(c_cached),
    .c_arready(c_arready), .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rlast(c_rlast),
    .c_rready(c_rready), .flush(flush), .err(err), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a transfer on either side.
  always @(negedge clk) begin
    if (!rst) begin
      if (c_rvalid && c_rready) begin
        if (exp_r.size() == 0) chk("unexpected_beat", {c_rlast, c_rdata}, 33'h0);
        else begin
          logic [32:0] e;
          e = exp_r.pop_front();
          chk("beat_data", c_rdata, e[31:0]);
          chk("beat_last", c_rlast, e[32]);
        end
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) chk("unexpected_ar", araddr, 32'h0);
        else begin
          logic [39:0] e;
          e = exp_ar.pop_front();
          chk("ar_addr", araddr, e[39:8]);
          chk("ar_len", arlen, e[7:0]);
          chk("ar_size_burst_id", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd0});
        end
      end
      if (err) err_seen++;
    end
  end

  task automatic do_req(input logic [31:0] a, input logic cached);
    int n;
    c_araddr  = a;
    c_cached  = cached;
    c_arvalid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!c_arready && n < 20);
    chk("accept_latency", n, 1);
    c_arvalid = 1'b0;
  endtask

  task automatic ar_hs(input int delay, input bit fl);
    for (int k = 0; k < delay; k++) begin
      flush = fl && (k == 0);
      #1;
      chk("arvalid_held", arvalid, 1'b1);
      tick();
    end
    flush   = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic run_beats(input int total, input logic [31:0] base, input int bad_beat,
                           input int flush_after, input bit drain, input bit toggle);
    int  i, cyc, fwd;
    bit  m_drain;
    logic acc, exp_rdy;
    i = 0; cyc = 0; fwd = 0;
    m_drain = drain;
    while (i < total && cyc < 200) begin
      rvalid   = 1'b1;
      rdata    = base + 32'(4 * i);
      rlast    = (i == total - 1);
      rresp    = (i == bad_beat) ? 2'b10 : 2'b00;
      c_rready = !(toggle && cyc == 2);
      flush    = !m_drain && flush_after >= 0 && fwd == flush_after;
      #1;
      exp_rdy = m_drain ? 1'b1 : (c_rready && !flush);
      chk("rready", rready, exp_rdy);
      acc = rready;
      if (!m_drain && exp_rdy) begin
        exp_r.push_back({rlast, rdata});
        fwd++;
      end
      if (flush) m_drain = 1'b1;
      tick();
      cyc++;
      if (acc) i++;
    end
    chk("beats_done", cyc < 200, 1'b1);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; flush = 1'b0; c_rready = 1'b1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    repeat (2) @(negedge clk);
    chk("rst_c_arready", c_arready, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_c_rvalid_rlast", {c_rvalid, c_rlast}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_araddr_arlen", {araddr, arlen}, 40'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Cached refill, AR ready on the second AR cycle.
    do_req(32'hf000_0044, 1'b1);
    exp_ar.push_back({32'hf000_0040, 8'd7});
    ar_hs(1, 1'b0);
    run_beats(8, 32'hf000_0040, -1, -1, 1'b0, 1'b0);

    // Uncached single beat, issued back-to-back.
    do_req(32'h1fc0_0008, 1'b0);
    exp_ar.push_back({32'h1fc0_0008, 8'd0});
    ar_hs(0, 1'b0);
    run_beats(1, 32'h1fc0_0008, -1, -1, 1'b0, 1'b0);

    // Cache backpressure mid-burst.
    do_req(32'h0000_1234, 1'b1);
    exp_ar.push_back({32'h0000_1220, 8'd7});
    ar_hs(0, 1'b0);
    run_beats(8, 32'h0000_1220, -1, -1, 1'b0, 1'b1);

    // Flush while AR is pending: burst is drained unseen.
    do_req(32'h2000_0010, 1'b1);
    exp_ar.push_back({32'h2000_0000, 8'd7});
    ar_hs(3, 1'b1);
    run_beats(8, 32'h2000_0000, -1, -1, 1'b1, 1'b0);

    // Flush after three forwarded beats.
    do_req(32'h3000_007c, 1'b1);
    exp_ar.push_back({32'h3000_0060, 8'd7});
    ar_hs(0, 1'b0);
    run_beats(8, 32'h3000_0060, -1, 3, 1'b0, 1'b0);
    tick();
    chk("err_none_yet", err_seen, 0);

    // SLVERR on beat 2 and premature RLAST on beat 6.
    e0 = err_seen;
    do_req(32'h4000_0000, 1'b1);
    exp_ar.push_back({32'h4000_0000, 8'd7});
    ar_hs(0, 1'b0);
    run_beats(6, 32'h4000_0000, 1, -1, 1'b0, 1'b0);
    tick();
    chk("err_pulses", err_seen - e0, 2);

    do_req(32'h5000_0000, 1'b0);
    exp_ar.push_back({32'h5000_0000, 8'd0});
    ar_hs(0, 1'b0);
    run_beats(1, 32'h5000_0000, -1, -1, 1'b0, 1'b0);
    tick();
    tick();
    chk("r_queue_empty", exp_r.size(), 0);
    chk("ar_queue_empty", exp_ar.size(), 0);
    chk("err_total", err_seen, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
